// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the TX feeder state encoding.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Bundle of the system-side byte handshake, the serialiser handshake and
// the feeder status outputs.
//
// Handshake: a byte moves on a rising edge where wr_valid && wr_ready are
// both high. The source keeps wr_data stable and wr_valid high until that
// edge. wr_ready does not depend on wr_valid.
interface uart_tx_feeder_if #(
    parameter int DEPTH = 16
);
    import uart_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [UART_DATA_W-1:0] wr_data;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [UART_DATA_W-1:0] tx_data;
    logic                   tx_start;
    logic                   tx_busy;
    logic [CNT_W-1:0]       count;
    logic                   empty;
    logic                   ack_err;
    feeder_state_e          state_dbg;

    // System side plus serialiser: drives bytes and the busy flag.
    modport master (
        output wr_data, wr_valid, tx_busy,
        input  wr_ready, tx_data, tx_start, count, empty, ack_err, state_dbg
    );

    // The feeder itself.
    modport slave (
        input  wr_data, wr_valid, tx_busy,
        output wr_ready, tx_data, tx_start, count, empty, ack_err, state_dbg
    );

endinterface

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO. Occupancy is kept in its own counter so full and
// empty never need pointer comparison; pointers simply wrap.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]       count,
    output logic                   full,
    output logic                   empty
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    // Next pointers and occupancy; push and pop together leave count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);

endmodule

// File: rtl/uart_tx_feeder.sv
// UART TX feeder: buffers bytes in a FIFO and hands them one at a time to
// the serialiser with a one-cycle start pulse, then follows tx_busy. A start
// that never sees busy rise within ACK_TIMEOUT cycles drops the byte and
// sets a sticky error.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              txrst,
    uart_tx_feeder_if.slave   bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ACK_W = $clog2(ACK_TIMEOUT);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [UART_DATA_W-1:0] fifo_rd_data;
    logic [CNT_W-1:0]       fifo_count;

    feeder_state_e          state_q, state_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;
    logic [ACK_W-1:0]       ack_cnt_q, ack_cnt_d;
    logic [ACK_W-1:0]       ack_cnt_inc;
    logic                   ack_err_q, ack_err_d;

    // wr_ready comes from the registered count only, so a pop in the same
    // cycle cannot open the door early.
    assign fifo_push = bus.wr_valid && !fifo_full;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (txrst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (bus.wr_data),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign ack_cnt_inc = ack_cnt_q + ACK_W'(1);

    // Feeder next-state: pop in IDLE, pulse in START, wait for busy to rise
    // (with timeout), then wait for busy to fall.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        ack_cnt_d  = ack_cnt_q;
        ack_err_d  = ack_err_q;
        fifo_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tx_data_d  = fifo_rd_data;
                    tx_start_d = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                ack_cnt_d = '0;
                state_d   = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    ack_cnt_d = ack_cnt_inc;
                    if (ack_cnt_inc == ACK_LAST) begin
                        ack_err_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Feeder state and registered outputs.
    always_ff @(posedge clk) begin
        if (txrst) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            ack_cnt_q  <= '0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            ack_cnt_q  <= ack_cnt_d;
            ack_err_q  <= ack_err_d;
        end
    end

    assign bus.wr_ready  = !fifo_full;
    assign bus.empty     = fifo_empty;
    assign bus.count     = fifo_count;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.ack_err   = ack_err_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a registered serialiser model.
module tb_uart_tx_feeder;
    import uart_pkg::*;

    localparam int DEPTH       = 16;
    localparam int ACK_TIMEOUT = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic txrst;
    always #5 clk = ~clk;

    uart_tx_feeder_if #(.DEPTH(DEPTH)) bus();

    uart_tx_feeder #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk   (clk),
        .txrst (txrst),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    logic [7:0] exp_q[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- serialiser model + scoreboard ----------------
    bit busy_en   = 1'b1;
    int busy_len  = 10;
    bit pend;
    int bcnt;
    int fall_cyc;
    bit fall_valid;
    bit gap_check = 1'b0;
    int frames    = 0;
    bit prev_start;
    int max_count = 0;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (txrst) begin
            pend        = 1'b0;
            bcnt        = 0;
            bus.tx_busy = 1'b0;
            prev_start  = 1'b0;
            fall_valid  = 1'b0;
        end else begin
            if (int'(bus.count) > max_count) max_count = int'(bus.count);
            if (bus.tx_start) begin
                frames++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_unexpected_start: tx_data=%h, nothing queued", bus.tx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (bus.tx_data !== exp_b) begin
                        tests_failed++;
                        $display("FAIL sb_tx_data: got %h want %h", bus.tx_data, exp_b);
                    end
                end
                tests_run++;
                if (prev_start) begin
                    tests_failed++;
                    $display("FAIL sb_start_width: tx_start high 2 cycles, want 1");
                end
                if (gap_check && fall_valid) begin
                    tests_run++;
                    if (cyc - fall_cyc != 2) begin
                        tests_failed++;
                        $display("FAIL sb_gap: busy-low to start %0d cycles, want 2", cyc - fall_cyc);
                    end
                end
                fall_valid = 1'b0;
            end
            prev_start = bus.tx_start;
            // busy rises one cycle after the start pulse, lasts busy_len cycles
            if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) begin
                    bus.tx_busy = 1'b0;
                    fall_cyc    = cyc;
                    fall_valid  = 1'b1;
                end
            end
            if (pend) begin
                pend        = 1'b0;
                bus.tx_busy = 1'b1;
                bcnt        = busy_len;
            end
            if (bus.tx_start && busy_en) pend = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        bus.wr_data  = b;
        bus.wr_valid = 1'b1;
        while (!bus.wr_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            tests_run++;
            tests_failed++;
            $display("FAIL push_timeout: byte %h not accepted in 500 cycles", b);
        end else begin
            exp_q.push_back(b);
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_drained(input string name);
        int n = 0;
        while (n < 2000 && !(bus.empty && bus.state_dbg == IDLE && !bus.tx_busy)) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n >= 2000) begin
            tests_failed++;
            $display("FAIL %s_drain: not idle after 2000 cycles (count=%0d)", name, bus.count);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        txrst        = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        repeat (2) @(negedge clk);
        tests_run++; if (bus.count !== 5'd0)   begin tests_failed++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        tests_run++; if (bus.empty !== 1'b1)   begin tests_failed++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        tests_run++; if (bus.wr_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_wr_ready: got %b want 1", bus.wr_ready); end
        tests_run++; if (bus.tx_start !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_start: got %b want 0", bus.tx_start); end
        tests_run++; if (bus.tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
        tests_run++; if (bus.ack_err !== 1'b0)  begin tests_failed++; $display("FAIL reset_ack_err: got %b want 0", bus.ack_err); end
        tests_run++; if (bus.state_dbg !== IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want IDLE", bus.state_dbg); end
        txrst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        busy_len = 10;
        push_byte(8'hA5);
        tests_run++; if (bus.count !== 5'd1)    begin tests_failed++; $display("FAIL single_count_e: got %0d want 1", bus.count); end
        tests_run++; if (bus.tx_start !== 1'b0) begin tests_failed++; $display("FAIL single_start_e: got %b want 0", bus.tx_start); end
        @(negedge clk);
        tests_run++; if (bus.tx_start !== 1'b1) begin tests_failed++; $display("FAIL single_start_e1: got %b want 1", bus.tx_start); end
        tests_run++; if (bus.tx_data !== 8'hA5) begin tests_failed++; $display("FAIL single_data: got %h want a5", bus.tx_data); end
        tests_run++; if (bus.count !== 5'd0)    begin tests_failed++; $display("FAIL single_count_e1: got %0d want 0", bus.count); end
        @(negedge clk);
        tests_run++; if (bus.tx_start !== 1'b0) begin tests_failed++; $display("FAIL single_start_e2: got %b want 0", bus.tx_start); end
        wait_drained("single");
        tests_run++; if (bus.count !== 5'd0)    begin tests_failed++; $display("FAIL single_count_end: got %0d want 0", bus.count); end
    endtask

    task automatic test_burst();
        int f0 = frames;
        int first_stall = -1;
        int stall_cnt = -1;
        busy_len   = 10;
        fall_valid = 1'b0;
        gap_check  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (first_stall < 0 && !bus.wr_ready) begin
                first_stall = i;
                stall_cnt   = int'(bus.count);
            end
            push_byte(8'(i));
        end
        wait_drained("burst");
        gap_check = 1'b0;
        tests_run++; if (first_stall != 18) begin tests_failed++; $display("FAIL burst_stall_index: got %0d want 18", first_stall); end
        tests_run++; if (stall_cnt != 16)   begin tests_failed++; $display("FAIL burst_stall_count: got %0d want 16", stall_cnt); end
        tests_run++; if (frames - f0 != 20) begin tests_failed++; $display("FAIL burst_frames: got %0d want 20", frames - f0); end
        tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL burst_leftover: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        int f0 = frames;
        busy_len  = 2;
        max_count = 0;
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 8; i++) push_byte(8'(8'h40 + b * 8 + i));
            repeat (10) @(negedge clk);
        end
        wait_drained("wrap");
        tests_run++; if (max_count > DEPTH)  begin tests_failed++; $display("FAIL wrap_max_count: got %0d want <= %0d", max_count, DEPTH); end
        tests_run++; if (frames - f0 != 48)  begin tests_failed++; $display("FAIL wrap_frames: got %0d want 48", frames - f0); end
        tests_run++; if (bus.count !== 5'd0) begin tests_failed++; $display("FAIL wrap_count_end: got %0d want 0", bus.count); end
    endtask

    task automatic test_timeout();
        int f0 = frames;
        busy_len = 10;
        busy_en  = 1'b0;
        push_byte(8'h3C);
        repeat (ACK_TIMEOUT) @(negedge clk);
        tests_run++; if (bus.ack_err !== 1'b0)   begin tests_failed++; $display("FAIL timeout_early: ack_err got %b want 0", bus.ack_err); end
        @(negedge clk);
        tests_run++; if (bus.ack_err !== 1'b1)   begin tests_failed++; $display("FAIL timeout_set: ack_err got %b want 1", bus.ack_err); end
        tests_run++; if (bus.state_dbg !== IDLE) begin tests_failed++; $display("FAIL timeout_state: got %0d want IDLE", bus.state_dbg); end
        busy_en = 1'b1;
        push_byte(8'h3D);
        wait_drained("timeout");
        tests_run++; if (bus.ack_err !== 1'b1)   begin tests_failed++; $display("FAIL timeout_sticky: ack_err got %b want 1", bus.ack_err); end
        tests_run++; if (frames - f0 != 2)       begin tests_failed++; $display("FAIL timeout_frames: got %0d want 2", frames - f0); end
    endtask

    task automatic test_simul();
        int f0 = frames;
        int n = 0;
        busy_len = 10;
        for (int i = 0; i < 6; i++) push_byte(8'(8'h80 + i));
        while (n < 100 && !(bus.state_dbg == IDLE && bus.count == 5'd5)) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n >= 100) begin
            tests_failed++;
            $display("FAIL simul_wait: IDLE with count 5 not reached (count=%0d)", bus.count);
        end
        push_byte(8'h86);
        tests_run++; if (bus.count !== 5'd5)      begin tests_failed++; $display("FAIL simul_count: got %0d want 5", bus.count); end
        tests_run++; if (bus.state_dbg !== START) begin tests_failed++; $display("FAIL simul_state: got %0d want START", bus.state_dbg); end
        tests_run++; if (bus.tx_data !== 8'h81)   begin tests_failed++; $display("FAIL simul_data: got %h want 81", bus.tx_data); end
        wait_drained("simul");
        tests_run++; if (frames - f0 != 7)        begin tests_failed++; $display("FAIL simul_frames: got %0d want 7", frames - f0); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int f1;
        busy_len = 10;
        for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + i));
        while (n < 100 && bus.state_dbg != WAIT_DONE) begin
            @(negedge clk);
            n++;
        end
        tests_run++; if (bus.count !== 5'd4) begin tests_failed++; $display("FAIL mid_queued: got %0d want 4", bus.count); end
        txrst = 1'b1;
        @(negedge clk);
        tests_run++; if (bus.count !== 5'd0)    begin tests_failed++; $display("FAIL mid_count: got %0d want 0", bus.count); end
        tests_run++; if (bus.empty !== 1'b1)    begin tests_failed++; $display("FAIL mid_empty: got %b want 1", bus.empty); end
        tests_run++; if (bus.tx_start !== 1'b0) begin tests_failed++; $display("FAIL mid_tx_start: got %b want 0", bus.tx_start); end
        tests_run++; if (bus.ack_err !== 1'b0)  begin tests_failed++; $display("FAIL mid_ack_err: got %b want 0", bus.ack_err); end
        exp_q.delete();
        txrst = 1'b0;
        f1 = frames;
        repeat (40) @(negedge clk);
        tests_run++; if (frames != f1) begin tests_failed++; $display("FAIL mid_no_start: got %0d starts want 0", frames - f1); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single();
        test_burst();
        test_wrap();
        test_timeout();
        test_simul();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
